// File: rtl/id_issue_scoreboard.sv
// Decode-stage issue controller: classifies the SPARC instruction in decode and checks
// it against a busy-bit register scoreboard. Also reports the stall cause and counts stall cycles.
module id_issue_scoreboard #(
    parameter int BUS_INST_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dec_valid,
    input  logic [BUS_INST_WIDTH-1:0]  dec_inst,
    input  logic                       ex_ready,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    input  logic                       flush,
    output logic                       issue,
    output logic                       stall,
    output logic [1:0]                 stall_cause,
    output logic [31:0]                busy_vec,
    output logic [4:0]                 outstanding,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    // State encodings deliberately equal the stall_cause codes they track.
    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_HAZ = 2'b01,
        ST_LIM = 2'b10,
        ST_EXW = 2'b11
    } stall_state_e;

    localparam logic [31:0] NOP_INST = 32'h0100_0000;

    logic [31:0]                inst;
    logic [1:0]                 op;
    logic [2:0]                 op2;
    logic                       i_bit;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;

    logic                       src1_used;
    logic                       src2_used;
    logic                       src3_used;
    logic                       wr_en;
    logic [4:0]                 dest;
    logic                       writes;

    logic [31:0]                wb_mask;
    logic [31:0]                eff_busy;
    logic                       clear_hit;
    logic                       set_hit;
    logic                       raw;
    logic                       full;
    logic                       can_go;

    logic [31:0]                busy_q, busy_d;
    logic [4:0]                 outstanding_q, outstanding_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [STALL_CNT_WIDTH-1:0] stall_entries_q, stall_entries_d;
    stall_state_e               state_q, state_d;

    assign inst  = dec_inst[31:0];
    assign op    = inst[31:30];
    assign op2   = inst[24:22];
    assign i_bit = inst[13];
    assign rs1   = inst[18:14];
    assign rs2   = inst[4:0];
    assign rd    = inst[29:25];

    // NOTE: every output of a combinational block gets a default first; otherwise a path
    // that skips an assignment makes synthesis infer a latch.
    always_comb begin
        src1_used = 1'b0;
        src2_used = 1'b0;
        src3_used = 1'b0;
        wr_en     = 1'b0;
        dest      = rd;
        unique case (op)
            2'b00: wr_en = (op2 == 3'b100) && (inst != NOP_INST);
            2'b01: begin
                wr_en = 1'b1;
                dest  = 5'd15;
            end
            2'b10: begin
                src1_used = 1'b1;
                src2_used = ~i_bit;
                wr_en     = 1'b1;
            end
            default: begin
                src1_used = 1'b1;
                src2_used = ~i_bit;
                if (inst[21]) src3_used = 1'b1;   // store reads rd as data
                else          wr_en     = 1'b1;
            end
        endcase
    end

    assign writes = wr_en && (dest != 5'd0);

    // A writeback in this cycle forwards, so its register no longer counts as pending.
    assign wb_mask   = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign eff_busy  = busy_q & ~wb_mask;
    assign clear_hit = wb_valid && busy_q[wb_rd];

    assign raw  = (src1_used && eff_busy[rs1]) ||
                  (src2_used && eff_busy[rs2]) ||
                  (src3_used && eff_busy[rd]);
    assign full = writes &&
                  ((outstanding_q - 5'(clear_hit)) == 5'(MAX_OUTSTANDING));

    assign can_go  = dec_valid && !flush && !reset;
    assign issue   = can_go && !raw && !full && ex_ready;
    assign stall   = dec_valid && !issue && !reset;
    assign set_hit = issue && writes;

    always_comb begin
        stall_cause = 2'b00;
        if (can_go && !issue) begin
            if (raw)       stall_cause = 2'b01;
            else if (full) stall_cause = 2'b10;
            else           stall_cause = 2'b11;
        end
    end

    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q;
        if (flush) begin
            busy_d        = 32'd0;
            outstanding_d = 5'd0;
        end else begin
            if (clear_hit) busy_d[wb_rd] = 1'b0;
            if (set_hit)   busy_d[dest]  = 1'b1;
            // A set onto a register cleared in the same cycle nets to zero.
            outstanding_d = outstanding_q - 5'(clear_hit)
                          + 5'(set_hit && !eff_busy[dest]);
        end
    end

    always_comb begin
        state_d         = stall_state_e'(stall_cause);
        stall_cycles_d  = stall_cycles_q;
        stall_entries_d = stall_entries_q;
        if (stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
        if ((state_q == ST_RUN) && (state_d != ST_RUN) && (stall_entries_q != '1))
            stall_entries_d = stall_entries_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            busy_q          <= 32'd0;
            outstanding_q   <= 5'd0;
            stall_cycles_q  <= '0;
            stall_entries_q <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            outstanding_q   <= outstanding_d;
            stall_cycles_q  <= stall_cycles_d;
            stall_entries_q <= stall_entries_d;
        end
    end

    assign busy_vec     = busy_q;
    assign outstanding  = outstanding_q;
    assign stall_cycles = stall_cycles_q;

endmodule
